// File: rtl/descrambler_pkg.sv
// Shared constants, rate decoding and sync FSM state for the multirate x^58 + x^39 + 1 descrambler.
package descrambler_pkg;

  localparam logic [1:0] RATE_QUARTER = 2'b00;
  localparam logic [1:0] RATE_HALF    = 2'b01;
  localparam logic [1:0] RATE_FULL    = 2'b10;

  localparam int DEF_POLY_LEN = 58;
  localparam int DEF_TAP      = 39;

  typedef enum logic {
    FLUSH  = 1'b0,
    SYNCED = 1'b1
  } sync_state_t;

  // 2'b11 aliases the full rate.
  function automatic int rate_width(input logic [1:0] rate, input int maxwidth);
    case (rate)
      RATE_QUARTER: return maxwidth / 4;
      RATE_HALF:    return maxwidth / 2;
      default:      return maxwidth;
    endcase
  endfunction

endpackage

// File: rtl/descr_word_core.sv
// Combinational word step of the self-synchronising descrambler: descrambles the low i_width
// bits of i_din against the history and returns the history advanced by i_width bits.
module descr_word_core #(
  parameter int MAXWIDTH = 32,
  parameter int POLY_LEN = 58,
  parameter int TAP      = 39,
  parameter int WW       = $clog2(MAXWIDTH + 1)
) (
  input  logic [POLY_LEN-1:0] i_hist,
  input  logic [MAXWIDTH-1:0] i_din,
  input  logic [WW-1:0]       i_width,
  output logic [MAXWIDTH-1:0] o_dout,
  output logic [MAXWIDTH-1:0] o_din_w,
  output logic [POLY_LEN-1:0] o_hist
);

  localparam int EXT_W = POLY_LEN + MAXWIDTH;

  logic [MAXWIDTH-1:0] w_mask;
  logic [EXT_W-1:0]    w_ext;

  // History MSB is the most recent bit, so w_ext[m] is stream bit (n + m - POLY_LEN).
  always_comb begin
    w_mask = '0;
    for (int k = 0; k < MAXWIDTH; k++) begin
      w_mask[k] = (k < int'(i_width));
    end
    w_ext  = {i_din & w_mask, i_hist};
    o_dout = '0;
    for (int k = 0; k < MAXWIDTH; k++) begin
      o_dout[k] = w_mask[k] & (w_ext[POLY_LEN+k] ^ w_ext[POLY_LEN+k-TAP] ^ w_ext[k]);
    end
  end

  assign o_din_w = i_din & w_mask;
  assign o_hist  = POLY_LEN'(w_ext >> i_width);

endmodule

// File: rtl/multirate_descrambler.sv
// Multirate x^58 + x^39 + 1 descrambler with sync gating and bypass.
// Define DESCR_PIPE_EN to add a second output register stage (latency 2).
module multirate_descrambler
  import descrambler_pkg::*;
#(
  parameter int MAXWIDTH = 32,
  parameter int POLY_LEN = DEF_POLY_LEN,
  parameter int TAP      = DEF_TAP
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          rate,
  input  logic                bypass,
  input  logic                din_valid,
  input  logic [MAXWIDTH-1:0] din,
  output logic                dout_valid,
  output logic [MAXWIDTH-1:0] dout,
  output logic                synced
);

  localparam int WW = $clog2(MAXWIDTH + 1);
  localparam int FW = $clog2(POLY_LEN + MAXWIDTH + 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(POLY_LEN);

  function automatic logic [FW-1:0] sat_fill(input logic [FW-1:0] a, input logic [FW-1:0] b);
    logic [FW-1:0] s;
    s = a + b;
    return (s >= FILL_FULL) ? FILL_FULL : s;
  endfunction

  sync_state_t         r_state;
  logic [1:0]          r_rate_q;
  logic [POLY_LEN-1:0] r_hist;
  logic [FW-1:0]       r_fill;
  logic [MAXWIDTH-1:0] r_dout_p1;
  logic                r_vld_p1;
  logic                r_synced_p1;

  logic [WW-1:0]       w_width;
  logic                w_rate_chg;
  logic [POLY_LEN-1:0] w_hist_in;
  logic [FW-1:0]       w_fill_nxt;
  logic [MAXWIDTH-1:0] w_core_dout;
  logic [MAXWIDTH-1:0] w_din_w;
  logic [POLY_LEN-1:0] w_core_hist;
  logic                w_release;
  logic [MAXWIDTH-1:0] w_dout_sel;

  // A rate change restarts from an empty history; a word in that cycle is the first one in.
  assign w_width    = WW'(rate_width(rate, MAXWIDTH));
  assign w_rate_chg = (rate != r_rate_q);
  assign w_hist_in  = w_rate_chg ? '0 : r_hist;
  assign w_fill_nxt = sat_fill(w_rate_chg ? '0 : r_fill, FW'(w_width));
  assign w_release  = din_valid & (bypass | ((r_state == SYNCED) & ~w_rate_chg));
  assign w_dout_sel = bypass ? w_din_w : w_core_dout;

  descr_word_core #(
    .MAXWIDTH (MAXWIDTH),
    .POLY_LEN (POLY_LEN),
    .TAP      (TAP),
    .WW       (WW)
  ) u_core (
    .i_hist  (w_hist_in),
    .i_din   (din),
    .i_width (w_width),
    .o_dout  (w_core_dout),
    .o_din_w (w_din_w),
    .o_hist  (w_core_hist)
  );

  // ---- stage p1: history, fill, sync FSM and output register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= FLUSH;
      r_rate_q    <= RATE_QUARTER;
      r_hist      <= '0;
      r_fill      <= '0;
      r_dout_p1   <= '0;
      r_vld_p1    <= 1'b0;
      r_synced_p1 <= 1'b0;
    end else begin
      r_rate_q <= rate;
      if (w_rate_chg) begin
        r_hist  <= '0;
        r_fill  <= '0;
        r_state <= FLUSH;
      end
      if (din_valid) begin
        r_hist <= w_core_hist;
        r_fill <= w_fill_nxt;
        if (w_fill_nxt >= FILL_FULL) begin
          r_state <= SYNCED;
        end
      end
      r_synced_p1 <= (r_state == SYNCED) & ~w_rate_chg;
      r_vld_p1    <= w_release;
      if (w_release) begin
        r_dout_p1 <= w_dout_sel;
      end
    end
  end

`ifdef DESCR_PIPE_EN
  logic [MAXWIDTH-1:0] r_dout_p2;
  logic                r_vld_p2;
  logic                r_synced_p2;

  // ---- stage p2: optional retiming register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dout_p2   <= '0;
      r_vld_p2    <= 1'b0;
      r_synced_p2 <= 1'b0;
    end else begin
      r_dout_p2   <= r_dout_p1;
      r_vld_p2    <= r_vld_p1;
      r_synced_p2 <= r_synced_p1;
    end
  end

  assign dout       = r_dout_p2;
  assign dout_valid = r_vld_p2;
  assign synced     = r_synced_p2;
`else
  assign dout       = r_dout_p1;
  assign dout_valid = r_vld_p1;
  assign synced     = r_synced_p1;
`endif

endmodule
